// File: rtl/vmon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vmon_pkg
// Purpose  : Shared types and the sample classifier for the voltage-monitor
//            power-good generator.
// Contents : vmon_state_t   - per-rail window-comparator FSM states
//            sample_class_t - LOW / IN / HIGH classification of one sample
//            classify()     - unsigned window compare, HIGH has priority
// Revision : 1.0 - initial release
// ============================================================================
package vmon_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    RAMP  = 3'd1,
    QUAL  = 3'd2,
    GOOD  = 3'd3,
    FAULT = 3'd4
  } vmon_state_t;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_IN   = 2'd1,
    S_HIGH = 2'd2
  } sample_class_t;

  // Operands are zero-extended to 32 bits by the caller, so ADC widths up to
  // 32 bits are supported. HIGH is tested first; when uv > ov every value that
  // clears uv is already above ov, so nothing can classify IN.
  function automatic sample_class_t classify(
    input logic [31:0] data,
    input logic [31:0] uv,
    input logic [31:0] ov
  );
    if (data > ov) begin
      return S_HIGH;
    end else if (data >= uv) begin
      return S_IN;
    end else begin
      return S_LOW;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/vmon_rail_fsm.sv
`default_nettype none
// ============================================================================
// Module   : vmon_rail_fsm
// Purpose  : Window-comparator state machine for a single monitored rail.
//            Qualifies QUAL_SAMPLES consecutive in-window samples before
//            asserting power-good and drops it after FLT_SAMPLES consecutive
//            out-of-window samples. Faults are sticky until the enable drops.
// Ports    : clk      - system clock
//            rst      - synchronous active-high reset
//            i_ena    - monitor enable for this rail
//            i_smp    - a sample for this rail is present this cycle
//            i_cls    - classification of the present sample
//            o_pwrgd  - qualified power-good (registered)
//            o_ov     - sticky overvoltage flag (registered)
//            o_uv     - sticky undervoltage-after-good flag (registered)
// Revision : 1.0 - initial release
// ============================================================================
module vmon_rail_fsm
  import vmon_pkg::*;
#(
  parameter int QUAL_SAMPLES = 4,
  parameter int FLT_SAMPLES  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ena,
  input  logic          i_smp,
  input  sample_class_t i_cls,
  output logic          o_pwrgd,
  output logic          o_ov,
  output logic          o_uv
);

  localparam int c_CNT_MAX_VAL = (QUAL_SAMPLES > FLT_SAMPLES) ? QUAL_SAMPLES : FLT_SAMPLES;
  localparam int c_CNT_W       = $clog2(c_CNT_MAX_VAL + 1);

  // Transitions fire when the count already holds N-1 and the N-th sample
  // arrives, so the counter itself never has to represent N.
  localparam logic [c_CNT_W-1:0] c_QUAL_LAST = c_CNT_W'(QUAL_SAMPLES - 1);
  localparam logic [c_CNT_W-1:0] c_FLT_LAST  = c_CNT_W'(FLT_SAMPLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  vmon_state_t        r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_pwrgd;
  logic               r_ov;
  logic               r_uv;
  logic [c_CNT_W-1:0] w_cnt_inc;

  // Saturating increment.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : (r_cnt + c_CNT_ONE);

  always_ff @(posedge clk) begin
    // Enable removal wins over any sample accepted in the same cycle.
    if (rst || !i_ena) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_pwrgd <= 1'b0;
      r_ov    <= 1'b0;
      r_uv    <= 1'b0;
    end else begin
      case (r_state)
        OFF: begin
          r_state <= RAMP;
          r_cnt   <= '0;
        end

        RAMP: begin
          if (i_smp) begin
            if (i_cls == S_HIGH) begin
              r_state <= FAULT;
              r_ov    <= 1'b1;
            end else if (i_cls == S_IN) begin
              if (QUAL_SAMPLES <= 1) begin
                r_state <= GOOD;
                r_pwrgd <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_state <= QUAL;
                r_cnt   <= c_CNT_ONE;
              end
            end
          end
        end

        QUAL: begin
          if (i_smp) begin
            if (i_cls == S_HIGH) begin
              r_state <= FAULT;
              r_ov    <= 1'b1;
              r_cnt   <= '0;
            end else if (i_cls == S_IN) begin
              if (r_cnt >= c_QUAL_LAST) begin
                r_state <= GOOD;
                r_pwrgd <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state <= RAMP;
              r_cnt   <= '0;
            end
          end
        end

        GOOD: begin
          if (i_smp) begin
            if (i_cls == S_IN) begin
              r_cnt <= '0;
            end else if (r_cnt >= c_FLT_LAST) begin
              // HIGH and LOW share one bad-run count; the last sample of
              // the run decides which flag is raised.
              r_state <= FAULT;
              r_pwrgd <= 1'b0;
              r_cnt   <= '0;
              r_ov    <= (i_cls == S_HIGH);
              r_uv    <= (i_cls != S_HIGH);
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end

        FAULT: begin
          // Held until the sequencer removes the enable.
        end

        default: begin
          r_state <= OFF;
          r_cnt   <= '0;
          r_pwrgd <= 1'b0;
          r_ov    <= 1'b0;
          r_uv    <= 1'b0;
        end
      endcase
    end
  end

  assign o_pwrgd = r_pwrgd;
  assign o_ov    = r_ov;
  assign o_uv    = r_uv;

endmodule
`default_nettype wire

// File: rtl/vmon_pwrgd_gen.sv
`default_nettype none
// ============================================================================
// Module   : vmon_pwrgd_gen
// Purpose  : Voltage-monitor power-good generator. Demultiplexes a shared ADC
//            sample stream to per-rail window-comparator FSMs and reports
//            qualified power-good plus sticky OV/UV flags per rail.
// Ports    : CLOCK        - system clock
//            RESET        - synchronous active-high reset
//            VMON_ENA     - per-rail monitor enable from the sequencer
//            ADC_VALID    - one-cycle strobe, a sample is present
//            ADC_CHANNEL  - rail index of the present sample
//            ADC_DATA     - unsigned sample value
//            UV_THRESH    - per-rail UV thresholds, rail i at [i*ADC_WIDTH +: ADC_WIDTH]
//            OV_THRESH    - per-rail OV thresholds, same packing
//            VRAIL_PWRGD  - qualified per-rail power-good
//            VRAIL_OV     - sticky per-rail overvoltage flag
//            VRAIL_UV     - sticky per-rail undervoltage-after-good flag
// Revision : 1.0 - initial release
// ============================================================================
module vmon_pwrgd_gen
  import vmon_pkg::*;
#(
  parameter  int VRAILS       = 4,
  parameter  int ADC_WIDTH    = 12,
  parameter  int QUAL_SAMPLES = 4,
  parameter  int FLT_SAMPLES  = 2,
  localparam int CH_WIDTH     = (VRAILS > 1) ? $clog2(VRAILS) : 1
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic [VRAILS-1:0]             VMON_ENA,
  input  logic                          ADC_VALID,
  input  logic [CH_WIDTH-1:0]           ADC_CHANNEL,
  input  logic [ADC_WIDTH-1:0]          ADC_DATA,
  input  logic [VRAILS*ADC_WIDTH-1:0]   UV_THRESH,
  input  logic [VRAILS*ADC_WIDTH-1:0]   OV_THRESH,
  output logic [VRAILS-1:0]             VRAIL_PWRGD,
  output logic [VRAILS-1:0]             VRAIL_OV,
  output logic [VRAILS-1:0]             VRAIL_UV
);

  for (genvar gi = 0; gi < VRAILS; gi++) begin : g_rail
    logic          w_smp;
    sample_class_t w_cls;

    // Channel codes at or above VRAILS match no rail and are dropped.
    assign w_smp = ADC_VALID && (ADC_CHANNEL == CH_WIDTH'(gi));

    // Thresholds are live inputs, compared in the sample cycle itself.
    assign w_cls = classify(32'(ADC_DATA),
                            32'(UV_THRESH[gi*ADC_WIDTH +: ADC_WIDTH]),
                            32'(OV_THRESH[gi*ADC_WIDTH +: ADC_WIDTH]));

    vmon_rail_fsm #(
      .QUAL_SAMPLES (QUAL_SAMPLES),
      .FLT_SAMPLES  (FLT_SAMPLES)
    ) u_rail_fsm (
      .clk     (CLOCK),
      .rst     (RESET),
      .i_ena   (VMON_ENA[gi]),
      .i_smp   (w_smp),
      .i_cls   (w_cls),
      .o_pwrgd (VRAIL_PWRGD[gi]),
      .o_ov    (VRAIL_OV[gi]),
      .o_uv    (VRAIL_UV[gi])
    );
  end

endmodule
`default_nettype wire
